// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS-lite multicycle controller: states, opcodes and mux select codes.
package mips_ctrl_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OPCODE_W = 6;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_HALT   = 4'd12
    } state_e;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUSRCB_RT    = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// Multicycle control FSM for the MIPS-lite datapath: Moore decode per state, with the
// memory-state enables qualified by mem_ready and every output held low while reset is high.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned ILLEGAL_HALT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pcwrite,
    output logic                pcwritecond,
    output logic                iord,
    output logic                memread,
    output logic                memwrite,
    output logic                irwrite,
    output logic                memtoreg,
    output logic                regdst,
    output logic                regwrite,
    output logic                alusrca,
    output logic [1:0]          alusrcb,
    output logic [1:0]          aluop,
    output logic [1:0]          pcsource,
    output logic [STATE_W-1:0]  state,
    output logic                halted
);

    state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next-state logic; opcode is consulted in DECODE and MEMADR only.
    always_comb begin
        state_d = S_FETCH;
        unique case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if      (opcode == OP_RTYPE)                    state_d = S_EXEC;
                else if (opcode == OP_LW || opcode == OP_SW)    state_d = S_MEMADR;
                else if (opcode == OP_BEQ)                      state_d = S_BRANCH;
                else if (opcode == OP_ADDI)                     state_d = S_ADDIEX;
                else if (opcode == OP_J)                        state_d = S_JUMP;
                else    state_d = (ILLEGAL_HALT != 0) ? S_HALT : S_FETCH;
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_RTWB;
            S_RTWB:   state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Output decode; everything defaults low and reset suppresses any partial write.
    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = ALUSRCB_RT;
        aluop       = ALUOP_ADD;
        pcsource    = PCSRC_ALU;
        halted      = 1'b0;
        if (!reset) begin
            unique case (state_q)
                S_FETCH: begin
                    memread = 1'b1;
                    alusrcb = ALUSRCB_FOUR;
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                end
                S_DECODE: alusrcb = ALUSRCB_IMMSH;
                S_MEMADR, S_ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = ALUSRCB_IMM;
                end
                S_MEMRD: begin
                    memread = 1'b1;
                    iord    = 1'b1;
                end
                S_MEMWB: begin
                    memtoreg = 1'b1;
                    regwrite = 1'b1;
                end
                S_MEMWR: begin
                    memwrite = 1'b1;
                    iord     = 1'b1;
                end
                S_EXEC: begin
                    alusrca = 1'b1;
                    aluop   = ALUOP_FUNCT;
                end
                S_RTWB: begin
                    regdst   = 1'b1;
                    regwrite = 1'b1;
                end
                S_BRANCH: begin
                    alusrca     = 1'b1;
                    aluop       = ALUOP_SUB;
                    pcwritecond = 1'b1;
                    pcsource    = PCSRC_ALUOUT;
                end
                S_ADDIWB: regwrite = 1'b1;
                S_JUMP: begin
                    pcwrite  = 1'b1;
                    pcsource = PCSRC_JUMP;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign state = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: state sequences, control vectors per state, stalls, halt and reset abort.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;

    logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic       memtoreg, regdst, regwrite, alusrca, halted;
    logic [1:0] alusrcb, aluop, pcsource;
    logic [3:0] state;

    logic       n_pcwrite, n_pcwritecond, n_iord, n_memread, n_memwrite, n_irwrite;
    logic       n_memtoreg, n_regdst, n_regwrite, n_alusrca, n_halted;
    logic [1:0] n_alusrcb, n_aluop, n_pcsource;
    logic [3:0] n_state;

    int tests_run = 0;
    int tests_failed = 0;
    int both_mem = 0;
    int wr_accepts = 0;

    always #5 clk = ~clk;

    multicycle_control #(.ILLEGAL_HALT(1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
        .memwrite(memwrite), .irwrite(irwrite), .memtoreg(memtoreg), .regdst(regdst),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
        .pcsource(pcsource), .state(state), .halted(halted)
    );

    multicycle_control #(.ILLEGAL_HALT(0)) dut_nop (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pcwrite(n_pcwrite), .pcwritecond(n_pcwritecond), .iord(n_iord), .memread(n_memread),
        .memwrite(n_memwrite), .irwrite(n_irwrite), .memtoreg(n_memtoreg), .regdst(n_regdst),
        .regwrite(n_regwrite), .alusrca(n_alusrca), .alusrcb(n_alusrcb), .aluop(n_aluop),
        .pcsource(n_pcsource), .state(n_state), .halted(n_halted)
    );

    // Field order: pcwrite pcwritecond iord memread memwrite irwrite memtoreg regdst regwrite alusrca alusrcb aluop pcsource halted
    localparam logic [16:0] C_ZERO   = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_FETCH  = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_FSTALL = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_DECODE = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] C_MEMADR = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] C_MEMRD  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_MEMWB  = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] C_MEMWR  = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_EXEC   = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] C_RTWB   = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] C_BRANCH = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] C_ADDIWB = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
    localparam logic [16:0] C_JUMP   = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
    localparam logic [16:0] C_HALT   = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_1;

    wire [16:0] ctl   = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
                         regdst, regwrite, alusrca, alusrcb, aluop, pcsource, halted};
    wire [16:0] n_ctl = {n_pcwrite, n_pcwritecond, n_iord, n_memread, n_memwrite, n_irwrite,
                         n_memtoreg, n_regdst, n_regwrite, n_alusrca, n_alusrcb, n_aluop,
                         n_pcsource, n_halted};

    always @(posedge clk) begin
        if (memread && memwrite) both_mem <= both_mem + 1;
        if (memwrite && mem_ready) wr_accepts <= wr_accepts + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check current state and controls with the given mem_ready, then advance one cycle.
    task automatic cyc(input string tag, input logic rdy, input logic [3:0] exp_st,
                       input logic [16:0] exp_ctl);
        mem_ready = rdy;
        #1;
        check({tag, ".state"}, 32'(state), 32'(exp_st));
        check({tag, ".ctl"}, 32'(ctl), 32'(exp_ctl));
        tick();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            check("reset.state", 32'(state), 32'd0);
            check("reset.ctl", 32'(ctl), 32'(C_ZERO));
            tick();
        end
        reset = 1'b0;
    endtask

    int acc_before;

    initial begin
        reset     = 1'b1;
        opcode    = 6'b100011;
        mem_ready = 1'b1;
        #1;
        do_reset(2);

        // lw: 0,1,2,3,4,0
        cyc("lw.fetch", 1'b1, 4'd0, C_FETCH);
        cyc("lw.decode", 1'b1, 4'd1, C_DECODE);
        cyc("lw.memadr", 1'b1, 4'd2, C_MEMADR);
        cyc("lw.memrd", 1'b1, 4'd3, C_MEMRD);
        cyc("lw.memwb", 1'b1, 4'd4, C_MEMWB);

        // sw with three stall cycles in MEMWR
        opcode = 6'b101011;
        cyc("sw.fetch", 1'b1, 4'd0, C_FETCH);
        cyc("sw.decode", 1'b0, 4'd1, C_DECODE);
        cyc("sw.memadr", 1'b0, 4'd2, C_MEMADR);
        cyc("sw.memwr0", 1'b0, 4'd5, C_MEMWR);
        cyc("sw.memwr1", 1'b0, 4'd5, C_MEMWR);
        cyc("sw.memwr2", 1'b0, 4'd5, C_MEMWR);
        cyc("sw.memwr3", 1'b1, 4'd5, C_MEMWR);

        // R-type, with one FETCH stall first
        opcode = 6'b000000;
        cyc("rt.fstall", 1'b0, 4'd0, C_FSTALL);
        cyc("rt.fetch", 1'b1, 4'd0, C_FETCH);
        cyc("rt.decode", 1'b1, 4'd1, C_DECODE);
        cyc("rt.exec", 1'b1, 4'd6, C_EXEC);
        cyc("rt.rtwb", 1'b1, 4'd7, C_RTWB);

        // beq then j; mem_ready low outside memory states is ignored
        opcode = 6'b000100;
        cyc("beq.fetch", 1'b1, 4'd0, C_FETCH);
        cyc("beq.decode", 1'b0, 4'd1, C_DECODE);
        cyc("beq.branch", 1'b0, 4'd8, C_BRANCH);
        opcode = 6'b000010;
        cyc("j.fetch", 1'b1, 4'd0, C_FETCH);
        cyc("j.decode", 1'b1, 4'd1, C_DECODE);
        cyc("j.jump", 1'b1, 4'd11, C_JUMP);

        // addi
        opcode = 6'b001000;
        cyc("addi.fetch", 1'b1, 4'd0, C_FETCH);
        cyc("addi.decode", 1'b1, 4'd1, C_DECODE);
        cyc("addi.ex", 1'b1, 4'd9, C_MEMADR);
        cyc("addi.wb", 1'b1, 4'd10, C_ADDIWB);

        // illegal opcode: one instance halts, the other treats it as a NOP
        opcode = 6'b111111;
        cyc("ill.fetch", 1'b1, 4'd0, C_FETCH);
        cyc("ill.decode", 1'b1, 4'd1, C_DECODE);
        #1;
        check("ill.nop_state", 32'(n_state), 32'd0);
        check("ill.nop_ctl", 32'(n_ctl), 32'(C_FETCH));
        for (int i = 0; i < 10; i++) cyc("ill.halt", i[0], 4'd12, C_HALT);
        opcode = 6'b100011;
        do_reset(1);
        cyc("ill.after_reset", 1'b1, 4'd0, C_FETCH);

        // reset asserted while stalled in MEMWR abandons the store
        opcode = 6'b101011;
        cyc("abort.decode", 1'b0, 4'd1, C_DECODE);
        cyc("abort.memadr", 1'b0, 4'd2, C_MEMADR);
        cyc("abort.memwr", 1'b0, 4'd5, C_MEMWR);
        acc_before = wr_accepts;
        mem_ready = 1'b0;
        do_reset(2);
        cyc("abort.fetch", 1'b0, 4'd0, C_FSTALL);
        check("abort.no_accept", 32'(wr_accepts), 32'(acc_before));

        check("inv.memread_memwrite", 32'(both_mem), 32'd0);
        check("inv.total_accepts", 32'(wr_accepts), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
